// File: rtl/pc_test_monitor.sv
// End-of-test monitor for the single-cycle RV32 core.
// Taps the PC stream, matches it against NUM_WATCH pass/fail watch points,
// and also ends the run on a cycle-count timeout or a repeated-PC hang.
// The verdict is registered: done/status/hit_idx appear one clock after the deciding edge.
module pc_test_monitor #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int NUM_WATCH = 4,
  parameter int IDX_W     = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pc_valid,
  input  logic [XLEN-1:0]           pc,
  input  logic [NUM_WATCH-1:0]      watch_en,
  input  logic [NUM_WATCH*XLEN-1:0] watch_cur,
  input  logic [NUM_WATCH*XLEN-1:0] watch_prev,
  input  logic [NUM_WATCH-1:0]      watch_use_prev,
  input  logic [NUM_WATCH-1:0]      watch_is_fail,
  input  logic [CNT_W-1:0]          max_cycles,
  input  logic [CNT_W-1:0]          hang_limit,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                status,
  output logic [IDX_W-1:0]          hit_idx,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [XLEN-1:0]           last_pc
);

  localparam logic [2:0] ST_NONE = 3'd0, ST_PASS = 3'd1, ST_FAIL = 3'd2,
                         ST_TMO  = 3'd3, ST_HANG = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  // Shadow copy of the configuration, frozen at the arming edge
  logic [NUM_WATCH-1:0]      cfg_en, cfg_use_prev, cfg_is_fail;
  logic [NUM_WATCH*XLEN-1:0] cfg_cur, cfg_prev;
  logic [CNT_W-1:0]          cfg_max, cfg_hang;

  logic             prev_valid;
  logic [CNT_W-1:0] hang_cnt, hang_inc, cnt_inc;
  logic [NUM_WATCH-1:0] match;
  logic             fail_hit, pass_hit, hang_fire, tmo_fire, repeat_pc;
  logic [IDX_W-1:0] fail_idx, pass_idx;
  logic             verdict;
  logic [2:0]       verdict_code;
  logic [IDX_W-1:0] verdict_idx;

  // Per-point match against the shadow config; transition points need a prior sample
  for (genvar i = 0; i < NUM_WATCH; i++) begin : g_match
    assign match[i] = cfg_en[i] & pc_valid & (pc == cfg_cur[i*XLEN +: XLEN]) &
                      (~cfg_use_prev[i] | (prev_valid & (last_pc == cfg_prev[i*XLEN +: XLEN])));
  end

  assign repeat_pc = pc_valid & prev_valid & (pc == last_pc);
  assign hang_inc  = (hang_cnt == '1) ? hang_cnt : hang_cnt + CNT_W'(1);
  assign cnt_inc   = cycle_cnt + CNT_W'(1);
  assign hang_fire = repeat_pc & (cfg_hang != '0) & (hang_inc == cfg_hang);
  assign tmo_fire  = (cfg_max != '0) & (cnt_inc == cfg_max);

  // Lowest-index fail and pass hits (descending scan so the lowest index wins)
  always_comb begin
    fail_hit = 1'b0;
    pass_hit = 1'b0;
    fail_idx = '0;
    pass_idx = '0;
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      if (match[i] & cfg_is_fail[i]) begin
        fail_hit = 1'b1;
        fail_idx = IDX_W'(i);
      end
      if (match[i] & ~cfg_is_fail[i]) begin
        pass_hit = 1'b1;
        pass_idx = IDX_W'(i);
      end
    end
  end

  // Verdict priority: fail, pass, hang, timeout; only while running and not re-arming
  always_comb begin
    verdict      = 1'b0;
    verdict_code = ST_NONE;
    verdict_idx  = '0;
    if (state == S_RUN && !start) begin
      verdict = 1'b1;
      if (fail_hit) begin
        verdict_code = ST_FAIL;
        verdict_idx  = fail_idx;
      end else if (pass_hit) begin
        verdict_code = ST_PASS;
        verdict_idx  = pass_idx;
      end else if (hang_fire) begin
        verdict_code = ST_HANG;
      end else if (tmo_fire) begin
        verdict_code = ST_TMO;
      end else begin
        verdict = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: start always (re-)arms, the first verdict ends the run
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (start) state_nxt = S_RUN;
               else if (verdict) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Config shadow, counters, PC history and registered verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_en       <= '0;
      cfg_use_prev <= '0;
      cfg_is_fail  <= '0;
      cfg_cur      <= '0;
      cfg_prev     <= '0;
      cfg_max      <= '0;
      cfg_hang     <= '0;
      prev_valid   <= 1'b0;
      hang_cnt     <= '0;
      cycle_cnt    <= '0;
      last_pc      <= '0;
      status       <= ST_NONE;
      hit_idx      <= '0;
    end else if (start) begin
      cfg_en       <= watch_en;
      cfg_use_prev <= watch_use_prev;
      cfg_is_fail  <= watch_is_fail;
      cfg_cur      <= watch_cur;
      cfg_prev     <= watch_prev;
      cfg_max      <= max_cycles;
      cfg_hang     <= hang_limit;
      prev_valid   <= 1'b0;
      hang_cnt     <= '0;
      cycle_cnt    <= '0;
      status       <= ST_NONE;
      hit_idx      <= '0;
    end else if (state == S_RUN) begin
      if (cycle_cnt != '1) cycle_cnt <= cnt_inc;
      if (pc_valid) begin
        last_pc    <= pc;
        prev_valid <= 1'b1;
        if (repeat_pc)         hang_cnt <= hang_inc;
        else if (pc != last_pc) hang_cnt <= '0;
      end
      if (verdict) begin
        status  <= verdict_code;
        hit_idx <= verdict_idx;
      end
    end
  end

endmodule

// File: tb/tb_pc_test_monitor.sv
// Randomized + directed bench for pc_test_monitor against a queue-based reference model.
module tb_pc_test_monitor;
  localparam int XLEN = 32, CNT_W = 32, NW = 4, IDX_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1, start = 1'b0, pc_valid = 1'b0;
  logic [XLEN-1:0]      pc = '0;
  logic [NW-1:0]        watch_en = '0, watch_use_prev = '0, watch_is_fail = '0;
  logic [NW*XLEN-1:0]   watch_cur = '0, watch_prev = '0;
  logic [CNT_W-1:0]     max_cycles = '0, hang_limit = '0;
  logic                 busy, done;
  logic [2:0]           status;
  logic [IDX_W-1:0]     hit_idx;
  logic [CNT_W-1:0]     cycle_cnt;
  logic [XLEN-1:0]      last_pc;

  pc_test_monitor #(.XLEN(XLEN), .CNT_W(CNT_W), .NUM_WATCH(NW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc(pc),
    .watch_en(watch_en), .watch_cur(watch_cur), .watch_prev(watch_prev),
    .watch_use_prev(watch_use_prev), .watch_is_fail(watch_is_fail),
    .max_cycles(max_cycles), .hang_limit(hang_limit),
    .busy(busy), .done(done), .status(status), .hit_idx(hit_idx),
    .cycle_cnt(cycle_cnt), .last_pc(last_pc));

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: run flag, verdict, and the list of PC samples taken since arming
  bit          m_armed = 0, m_done = 0;
  int          m_status = 0, m_hit = 0;
  longint      m_cycles = 0;
  logic [31:0] m_last_pc = '0;
  logic [31:0] m_hist[$];
  bit          c_en[NW], c_up[NW], c_fail[NW];
  logic [31:0] c_cur[NW], c_prev[NW];
  longint      c_max = 0, c_hang = 0;

  task automatic model_edge();
    int fidx, pidx, rep, vs, vh;
    if (rst) begin
      m_armed = 0; m_done = 0; m_status = 0; m_hit = 0; m_cycles = 0;
      m_last_pc = '0; m_hist.delete();
    end else if (start) begin
      for (int i = 0; i < NW; i++) begin
        c_en[i] = watch_en[i]; c_up[i] = watch_use_prev[i]; c_fail[i] = watch_is_fail[i];
        c_cur[i] = watch_cur[i*XLEN +: XLEN]; c_prev[i] = watch_prev[i*XLEN +: XLEN];
      end
      c_max = max_cycles; c_hang = hang_limit;
      m_armed = 1; m_done = 0; m_status = 0; m_hit = 0; m_cycles = 0; m_hist.delete();
    end else if (m_armed) begin
      if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      fidx = -1; pidx = -1; rep = 0;
      if (pc_valid) begin
        for (int i = 0; i < NW; i++) begin
          if (c_en[i] && pc == c_cur[i] &&
              (!c_up[i] || (m_hist.size() > 0 && m_hist[$] == c_prev[i]))) begin
            if (c_fail[i]) begin if (fidx < 0) fidx = i; end
            else if (pidx < 0) pidx = i;
          end
        end
        // Repeat count = number of earlier samples at the tail equal to this PC
        for (int k = m_hist.size() - 1; k >= 0; k--) begin
          if (m_hist[k] != pc) break;
          rep++;
        end
      end
      vs = 0; vh = 0;
      if (fidx >= 0) begin vs = 2; vh = fidx; end
      else if (pidx >= 0) begin vs = 1; vh = pidx; end
      else if (c_hang != 0 && rep == c_hang) vs = 4;
      else if (c_max != 0 && m_cycles == c_max) vs = 3;
      if (pc_valid) begin m_hist.push_back(pc); m_last_pc = pc; end
      if (vs != 0) begin m_armed = 0; m_done = 1; m_status = vs; m_hit = vh; end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", busy, 64'(m_armed));
    chk("done", done, 64'(m_done));
    chk("status", status, 64'(m_status));
    chk("hit_idx", hit_idx, 64'(m_hit));
    chk("cycle_cnt", cycle_cnt, 64'(m_cycles));
    chk("last_pc", last_pc, 64'(m_last_pc));
  endtask

  task automatic clear_cfg();
    watch_en = '0; watch_use_prev = '0; watch_is_fail = '0;
    watch_cur = '0; watch_prev = '0; max_cycles = '0; hang_limit = '0;
  endtask

  task automatic set_point(input int i, input bit en, input bit up, input bit fl,
                           input logic [31:0] cur, input logic [31:0] prv);
    watch_en[i] = en; watch_use_prev[i] = up; watch_is_fail[i] = fl;
    watch_cur[i*XLEN +: XLEN] = cur; watch_prev[i*XLEN +: XLEN] = prv;
  endtask

  task automatic arm();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic sample(input logic [31:0] v);
    pc_valid = 1'b1; pc = v; tick(); pc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_status", status, 0);
    chk("rst_cycle", cycle_cnt, 0); chk("rst_last_pc", last_pc, 0);

    // 1: transition pass 0x45C->0x47C
    clear_cfg(); set_point(0, 1, 1, 0, 32'h47C, 32'h45C); max_cycles = 2000;
    arm();
    for (int a = 0; a <= 'h45C; a += 4) sample(32'(a));
    chk("t1_pre_done", done, 0);
    sample(32'h47C);
    chk("t1_done", done, 1); chk("t1_status", status, 1); chk("t1_hit", hit_idx, 0);
    chk("t1_busy", busy, 0); chk("t1_last_pc", last_pc, 32'h47C);

    // 2: wrong predecessor, then right one; then arrival match on first sample
    arm();
    sample(32'h440); sample(32'h47C);
    chk("t2_no_verdict", done, 0);
    sample(32'h45C); sample(32'h47C);
    chk("t2_status", status, 1);
    set_point(0, 1, 0, 0, 32'h47C, 32'h0);
    arm(); sample(32'h47C);
    chk("t2_arrival_done", done, 1); chk("t2_arrival_status", status, 1);

    // 3: fail beats pass on the same PC
    clear_cfg();
    set_point(1, 1, 0, 1, 32'h500, 0); set_point(2, 1, 0, 0, 32'h500, 0);
    arm(); sample(32'h500);
    chk("t3_status", status, 2); chk("t3_hit", hit_idx, 1);

    // 4: timeout after exactly max_cycles clocks; disabled timeout keeps running
    clear_cfg(); max_cycles = 10;
    arm();
    max_cycles = 3;  // must not affect the armed run
    idle(9);
    chk("t4_early", done, 0);
    idle(1);
    chk("t4_status", status, 3); chk("t4_cycles", cycle_cnt, 10);
    max_cycles = 0;
    arm(); idle(5000);
    chk("t4_busy", busy, 1); chk("t4_cycles_long", cycle_cnt, 5000);

    // 5: hang on four equal samples; interleaved PC breaks the run
    clear_cfg(); hang_limit = 3;
    arm();
    sample(32'h100); sample(32'h100); sample(32'h100);
    chk("t5_no_hang_yet", done, 0);
    sample(32'h100);
    chk("t5_status", status, 4);
    arm();
    sample(32'h100); sample(32'h100); sample(32'h104); sample(32'h100);
    sample(32'h100); sample(32'h104); sample(32'h100); sample(32'h100);
    chk("t5_no_hang", busy, 1);

    // 6: reset mid-run, reset beats start, then clean arm
    clear_cfg();
    arm(); idle(50);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_busy", busy, 0); chk("t6_cycles", cycle_cnt, 0); chk("t6_last_pc", last_pc, 0);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk("t6_rst_wins", busy, 0);
    arm();
    chk("t6_armed", busy, 1); chk("t6_cnt0", cycle_cnt, 0);
    idle(3);
    chk("t6_cnt3", cycle_cnt, 3);

    // Random phase: config churns every cycle, occasional start/rst
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom % 500) == 0;
      start = ($urandom % 40) == 0;
      pc_valid = ($urandom % 4) != 0;
      pc = 32'h100 + 32'(4 * ($urandom % 5));
      for (int i = 0; i < NW; i++)
        set_point(i, ($urandom % 3) == 0, $urandom % 2, $urandom % 2,
                  32'h100 + 32'(4 * ($urandom % 5)), 32'h100 + 32'(4 * ($urandom % 5)));
      max_cycles = ($urandom % 3 == 0) ? '0 : CNT_W'($urandom_range(5, 60));
      hang_limit = ($urandom % 3 == 0) ? '0 : CNT_W'($urandom_range(1, 5));
      tick();
    end
    rst = 1'b0; start = 1'b0; pc_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_test_monitor.md
Name: pc_test_monitor

Overview:
- Synthesizable end-of-test monitor for the single-cycle RV32 core; generalised successor of the single-address bench pass check.
- Watches the PC stream and reports completion. Any of NUM_WATCH PC watch points can be marked pass or fail.
- Adds a cycle-count timeout and a hang detector. Status registers are exposed for the bench or a debug port.
- Sits beside cpu_top and taps pc_current_s1.

Parameters:
XLEN, 32, PC width
CNT_W, 32, cycle/hang counter width
NUM_WATCH, 4, number of watch points (>=1)
IDX_W, $clog2(NUM_WATCH) (min 1), hit index width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
start  in  1  arm monitor: latch config, clear counters
pc_valid  in  1  pc carries a new sample this cycle
pc  in  XLEN  current PC
watch_en  in  NUM_WATCH  per-point enable
watch_cur  in  NUM_WATCH*XLEN  target PC, point i at [i*XLEN +: XLEN]
watch_prev  in  NUM_WATCH*XLEN  required preceding PC
watch_use_prev  in  NUM_WATCH  1 = transition match (prev->cur); 0 = arrival match
watch_is_fail  in  NUM_WATCH  1 = fail point; 0 = pass point
max_cycles  in  CNT_W  timeout limit; 0 disables
hang_limit  in  CNT_W  repeat-PC limit; 0 disables
busy  out  1  monitor armed, not yet done
done  out  1  verdict valid, sticky until start/rst
status  out  3  0 none, 1 pass, 2 fail, 3 timeout, 4 hang
hit_idx  out  IDX_W  index of matching watch point (pass/fail only, else 0)
cycle_cnt  out  CNT_W  clocks since arm, frozen at done
last_pc  out  XLEN  last sampled PC

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; busy=0, done=0, status=0, hit_idx=0, cycle_cnt=0, last_pc=0; prev_valid=0; hang count=0; latched config cleared. Reset wins over start in the same cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Config is latched into shadow registers. Later changes to the config inputs do not affect the run.
  - RUN -> DONE on the first verdict.
  - DONE holds until start, which re-arms directly to RUN. start while in RUN also re-arms: counters clear and prev_valid=0.
- cycle_cnt is cleared to 0 on the arming edge. It increments by 1 on every clock in RUN and saturates at all-ones.
- Sampling: on a posedge with pc_valid=1 in RUN, last_pc<=pc and prev_valid<=1. Samples in IDLE and DONE are ignored.
- Match for point i:
  - watch_en[i] & pc_valid & pc==watch_cur[i], and
  - either watch_use_prev[i]=0, or (prev_valid & last_pc==watch_prev[i]).
  - A transition match is impossible on the first sample after arming.
- Verdict priority within one cycle, highest first:
  1. fail match, lowest index
  2. pass match, lowest index
  3. hang
  4. timeout
- Timeout: in RUN, max_cycles!=0 and cycle_cnt+1 == max_cycles on this edge. The run therefore ends after exactly max_cycles clocks with cycle_cnt=max_cycles.
- Hang counter:
  - pc_valid & prev_valid & pc==last_pc: count+1.
  - pc_valid & pc!=last_pc: count = 0.
  - No pc_valid: count holds.
  - Hang fires when hang_limit!=0 and the incremented count == hang_limit.
- Latency: the verdict condition is evaluated combinationally from the current-cycle sample and registered. done=1, status, hit_idx and busy=0 appear one clock after the matching sample edge. The matching sample itself is still counted in cycle_cnt and written to last_pc.
- busy=1 exactly while in RUN. done and busy are never both 1.
- NUM_WATCH=1: hit_idx is 1 bit and always 0.

Test Plan:
1. Arm with point0 = transition 0x45C->0x47C (pass), max_cycles=2000; drive pc 0x000,0x004,...,0x45C,0x47C with pc_valid=1 -> one clock after the 0x47C sample: done=1, status=1, hit_idx=0, busy=0, last_pc=0x47C.
2. Same config; drive 0x47C directly after 0x440 -> no verdict. Then 0x45C,0x47C -> pass. Then arm with use_prev=0 and drive 0x47C as the first sample -> pass after 1 cycle.
3. Point1 = arrival 0x500 fail, point2 = arrival 0x500 pass; drive 0x500 -> status=2, hit_idx=1 (fail beats pass).
4. max_cycles=10, no matching PC -> done on the 10th clock after arming, status=3, cycle_cnt=10. With max_cycles=0 and no match for 5000 cycles -> busy stays 1.
5. hang_limit=3; drive 0x100 four consecutive valid samples -> status=4 one clock after the 4th sample. Inserting 0x104 between repeats resets the count and there is no hang.
6. Assert rst mid-run at cycle 50 -> all outputs 0, IDLE. Then start together with rst -> stays IDLE. Then start alone -> RUN, cycle_cnt counts from 0.
